// File: rtl/pipe_stage_skid.sv
// pipe_stage_skid: one pipeline stage with a main register and a skid register,
// so in_ready is a registered signal with no combinational path from
// out_ready or in_valid. It also supports a synchronous flush and keeps
// saturating stall and flush statistics.
module pipe_stage_skid #(
    parameter int DATA_W = 32,
    parameter int LANES  = 4,
    parameter int CTRL_W = 4,
    parameter int CNT_W  = 16
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    flush,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic [CTRL_W-1:0]       in_ctrl,
    input  logic [LANES*DATA_W-1:0] in_data,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [CTRL_W-1:0]       out_ctrl,
    output logic [LANES*DATA_W-1:0] out_data,
    output logic [1:0]              occupancy,
    output logic [CNT_W-1:0]        stall_cnt,
    output logic [CNT_W-1:0]        flush_cnt
);

    localparam int PAYLOAD_W = LANES * DATA_W;
    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    // The encoding doubles as the occupancy count.
    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        FULL  = 2'd2
    } state_t;

    state_t state;
    state_t next_state;

    logic                 in_ready_q;
    logic [CTRL_W-1:0]    main_ctrl;
    logic [PAYLOAD_W-1:0] main_data;
    logic [CTRL_W-1:0]    skid_ctrl;
    logic [PAYLOAD_W-1:0] skid_data;

    logic in_fire;
    logic out_fire;
    logic load_main_in;
    logic load_main_skid;
    logic load_skid;

    logic [1:0]     drop_count;
    logic [CNT_W:0] flush_sum;

    assign in_ready  = in_ready_q;
    assign out_valid = (state == ONE) || (state == FULL);
    assign out_ctrl  = main_ctrl;
    assign out_data  = main_data;
    assign occupancy = state;

    assign in_fire  = in_valid & in_ready_q;
    assign out_fire = out_valid & out_ready;

    // Next-state and register-load decisions; flush overrides everything.
    always_comb begin
        next_state     = state;
        load_main_in   = 1'b0;
        load_main_skid = 1'b0;
        load_skid      = 1'b0;
        if (flush) begin
            next_state = EMPTY;
        end else begin
            case (state)
                EMPTY: begin
                    if (in_fire) begin
                        load_main_in = 1'b1;
                        next_state   = ONE;
                    end
                end
                ONE: begin
                    if (in_fire && out_fire) begin
                        load_main_in = 1'b1;
                    end else if (in_fire) begin
                        load_skid  = 1'b1;
                        next_state = FULL;
                    end else if (out_fire) begin
                        next_state = EMPTY;
                    end
                end
                FULL: begin
                    if (out_fire) begin
                        load_main_skid = 1'b1;
                        next_state     = ONE;
                    end
                end
                default: begin
                    next_state = EMPTY;
                end
            endcase
        end
    end

    // Entries lost to a flush: what was stored and not delivered, plus any accepted input.
    always_comb begin
        drop_count = 2'd0;
        if (flush) begin
            drop_count = occupancy - {1'b0, out_fire} + {1'b0, in_fire};
        end
        flush_sum = {1'b0, flush_cnt} + {{(CNT_W-1){1'b0}}, drop_count};
    end

    // State register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= EMPTY;
        end else begin
            state <= next_state;
        end
    end

    // Registered ready: accept whenever the coming state still has a free slot.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            in_ready_q <= 1'b0;
        end else begin
            in_ready_q <= (next_state != FULL);
        end
    end

    // Main register; a bubble gets a cleared control field so it has no side effects.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            main_ctrl <= '0;
            main_data <= '0;
        end else if (next_state == EMPTY) begin
            main_ctrl <= '0;
        end else if (load_main_in) begin
            main_ctrl <= in_ctrl;
            main_data <= in_data;
        end else if (load_main_skid) begin
            main_ctrl <= skid_ctrl;
            main_data <= skid_data;
        end
    end

    // Skid register catches the entry accepted while the main register is stalled.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            skid_ctrl <= '0;
            skid_data <= '0;
        end else if (flush) begin
            skid_ctrl <= '0;
        end else if (load_skid) begin
            skid_ctrl <= in_ctrl;
            skid_data <= in_data;
        end
    end

    // Saturating count of cycles an entry waited on downstream.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            stall_cnt <= '0;
        end else if (out_valid && !out_ready && (stall_cnt != CNT_MAX)) begin
            stall_cnt <= stall_cnt + CNT_ONE;
        end
    end

    // Saturating count of entries discarded by flush.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            flush_cnt <= '0;
        end else if (flush) begin
            flush_cnt <= flush_sum[CNT_W] ? CNT_MAX : flush_sum[CNT_W-1:0];
        end
    end

endmodule

// File: tb/tb_pipe_stage_skid.sv
// Testbench for pipe_stage_skid: directed scenarios plus random traffic,
// checked against a queue-based reference model. A second instance with
// 2-bit counters exercises counter saturation on the same stimulus.
module tb_pipe_stage_skid;

    localparam int DATA_W = 32;
    localparam int LANES  = 4;
    localparam int CTRL_W = 4;
    localparam int CNT_W  = 16;
    localparam int PW     = DATA_W * LANES;

    logic          clk;
    logic          reset;
    logic          flush;
    logic          in_valid;
    logic          in_ready;
    logic [3:0]    in_ctrl;
    logic [PW-1:0] in_data;
    logic          out_valid;
    logic          out_ready;
    logic [3:0]    out_ctrl;
    logic [PW-1:0] out_data;
    logic [1:0]    occupancy;
    logic [15:0]   stall_cnt;
    logic [15:0]   flush_cnt;

    logic          s_in_ready;
    logic          s_out_valid;
    logic [3:0]    s_out_ctrl;
    logic [15:0]   s_out_data;
    logic [1:0]    s_occupancy;
    logic [1:0]    s_stall_cnt;
    logic [1:0]    s_flush_cnt;

    int n_checks;
    int n_errors;

    typedef struct packed {
        logic [3:0]    ctrl;
        logic [PW-1:0] data;
    } entry_t;

    entry_t        mq[$];
    logic [PW-1:0] m_last;
    int            m_stall;
    int            m_flush;
    bit            m_armed;

    pipe_stage_skid #(.DATA_W(DATA_W), .LANES(LANES), .CTRL_W(CTRL_W), .CNT_W(CNT_W)) dut (
        .clk(clk), .reset(reset), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready), .in_ctrl(in_ctrl), .in_data(in_data),
        .out_valid(out_valid), .out_ready(out_ready), .out_ctrl(out_ctrl), .out_data(out_data),
        .occupancy(occupancy), .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
    );

    pipe_stage_skid #(.DATA_W(8), .LANES(2), .CTRL_W(4), .CNT_W(2)) dut_small (
        .clk(clk), .reset(reset), .flush(flush),
        .in_valid(in_valid), .in_ready(s_in_ready), .in_ctrl(in_ctrl), .in_data(in_data[15:0]),
        .out_valid(s_out_valid), .out_ready(out_ready), .out_ctrl(s_out_ctrl), .out_data(s_out_data),
        .occupancy(s_occupancy), .stall_cnt(s_stall_cnt), .flush_cnt(s_flush_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic int sat(input int v, input int maxv);
        return (v > maxv) ? maxv : v;
    endfunction

    task automatic checkOutput(input string tag, input logic [PW-1:0] got, input logic [PW-1:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("[TB] FAIL %s: got %0h, expected %0h", tag, got, exp);
        end
    endtask

    task automatic modelReset();
        mq.delete();
        m_last  = '0;
        m_stall = 0;
        m_flush = 0;
        m_armed = 1'b0;
    endtask

    // Compare every output of both instances with the reference model.
    task automatic checkAll();
        logic [PW-1:0] e_valid;
        logic [PW-1:0] e_ctrl;
        logic [PW-1:0] e_ready;
        e_valid = (mq.size() > 0) ? 1 : 0;
        e_ctrl  = (mq.size() > 0) ? PW'(mq[0].ctrl) : '0;
        e_ready = (m_armed && mq.size() < 2) ? 1 : 0;
        checkOutput("occupancy", PW'(occupancy), PW'(mq.size()));
        checkOutput("out_valid", PW'(out_valid), e_valid);
        checkOutput("in_ready", PW'(in_ready), e_ready);
        checkOutput("out_ctrl", PW'(out_ctrl), e_ctrl);
        checkOutput("out_data", out_data, m_last);
        checkOutput("stall_cnt", PW'(stall_cnt), PW'(sat(m_stall, 65535)));
        checkOutput("flush_cnt", PW'(flush_cnt), PW'(sat(m_flush, 65535)));
        checkOutput("s_occupancy", PW'(s_occupancy), PW'(mq.size()));
        checkOutput("s_in_ready", PW'(s_in_ready), e_ready);
        checkOutput("s_out_ctrl", PW'(s_out_ctrl), e_ctrl);
        checkOutput("s_out_data", PW'(s_out_data), PW'(m_last[15:0]));
        checkOutput("s_stall_cnt", PW'(s_stall_cnt), PW'(sat(m_stall, 3)));
        checkOutput("s_flush_cnt", PW'(s_flush_cnt), PW'(sat(m_flush, 3)));
    endtask

    // Drive one cycle of inputs, advance the model across the edge, then check.
    task automatic applyStimulus(input logic iv, input logic [3:0] c, input logic [PW-1:0] d,
                                 input logic ordy, input logic fl);
        bit ifire;
        bit ofire;
        bit stalled;
        in_valid  = iv;
        in_ctrl   = c;
        in_data   = d;
        out_ready = ordy;
        flush     = fl;
        ifire   = iv && m_armed && (mq.size() < 2);
        ofire   = (mq.size() > 0) && ordy;
        stalled = (mq.size() > 0) && !ordy;
        @(posedge clk);
        #1;
        if (stalled) m_stall++;
        if (fl) begin
            m_flush += mq.size() - int'(ofire) + int'(ifire);
            mq.delete();
        end else begin
            if (ofire) void'(mq.pop_front());
            if (ifire) mq.push_back('{ctrl: c, data: d});
        end
        if (mq.size() > 0) m_last = mq[0].data;
        m_armed = 1'b1;
        checkAll();
    endtask

    task automatic doReset();
        reset     = 1'b1;
        flush     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        in_ctrl   = '0;
        in_data   = '0;
        #1;
        modelReset();
        checkAll();
        repeat (2) @(posedge clk);
        #3;
        reset = 1'b0;
        checkAll();
        applyStimulus(1'b0, 4'h0, '0, 1'b1, 1'b0);
        checkOutput("ready_after_reset", PW'(in_ready), 1);
    endtask

    initial begin
        n_checks = 0;
        n_errors = 0;
        doReset();

        // Streaming at full rate.
        applyStimulus(1'b1, 4'h3, {32'h4, 32'h3, 32'h2, 32'h1}, 1'b1, 1'b0);
        checkOutput("stream_first", out_data, {32'h4, 32'h3, 32'h2, 32'h1});
        applyStimulus(1'b1, 4'h3, {32'h8, 32'h7, 32'h6, 32'h5}, 1'b1, 1'b0);
        checkOutput("stream_second", out_data, {32'h8, 32'h7, 32'h6, 32'h5});
        checkOutput("stream_ctrl", PW'(out_ctrl), 3);
        applyStimulus(1'b0, 4'h0, '0, 1'b1, 1'b0);
        checkOutput("stream_drained", PW'(out_valid), 0);
        checkOutput("stream_no_stall", PW'(stall_cnt), 0);

        // Back-pressure then release, order preserved.
        doReset();
        applyStimulus(1'b1, 4'h5, {4{32'hAAAA0001}}, 1'b0, 1'b0);
        checkOutput("bp_occ_one", PW'(occupancy), 1);
        applyStimulus(1'b1, 4'h6, {4{32'hBBBB0002}}, 1'b0, 1'b0);
        checkOutput("bp_occ_full", PW'(occupancy), 2);
        checkOutput("bp_not_ready", PW'(in_ready), 0);
        applyStimulus(1'b1, 4'h7, {4{32'hCCCC0003}}, 1'b0, 1'b0);
        checkOutput("bp_stall_two", PW'(stall_cnt), 2);
        checkOutput("bp_head_a", out_data, {4{32'hAAAA0001}});
        applyStimulus(1'b0, 4'h0, '0, 1'b1, 1'b0);
        checkOutput("bp_head_b", PW'(out_ctrl), 6);
        checkOutput("bp_ready_again", PW'(in_ready), 1);
        applyStimulus(1'b0, 4'h0, '0, 1'b1, 1'b0);

        // Flush while full, nothing delivered.
        doReset();
        applyStimulus(1'b1, 4'h9, {4{32'h11111111}}, 1'b0, 1'b0);
        applyStimulus(1'b1, 4'hA, {4{32'h22222222}}, 1'b0, 1'b0);
        applyStimulus(1'b0, 4'h0, '0, 1'b0, 1'b1);
        checkOutput("flush_full_occ", PW'(occupancy), 0);
        checkOutput("flush_full_ctrl", PW'(out_ctrl), 0);
        checkOutput("flush_full_cnt", PW'(flush_cnt), 2);

        // Flush in ONE with a delivery and a dropped input.
        doReset();
        applyStimulus(1'b1, 4'hB, {4{32'h33333333}}, 1'b0, 1'b0);
        applyStimulus(1'b1, 4'hC, {4{32'h44444444}}, 1'b1, 1'b1);
        checkOutput("flush_one_cnt", PW'(flush_cnt), 1);
        checkOutput("flush_one_valid", PW'(out_valid), 0);

        // Small counter saturates at 3.
        doReset();
        applyStimulus(1'b1, 4'h1, {4{32'h55555555}}, 1'b0, 1'b0);
        for (int i = 0; i < 6; i++) applyStimulus(1'b0, 4'h0, '0, 1'b0, 1'b0);
        checkOutput("sat_small_stall", PW'(s_stall_cnt), 3);
        checkOutput("sat_big_stall", PW'(stall_cnt), 6);

        // Asynchronous reset between edges while full.
        doReset();
        applyStimulus(1'b1, 4'hD, {4{32'h66666666}}, 1'b0, 1'b0);
        applyStimulus(1'b1, 4'hE, {4{32'h77777777}}, 1'b0, 1'b0);
        #3;
        reset = 1'b1;
        #1;
        checkOutput("async_valid", PW'(out_valid), 0);
        checkOutput("async_ready", PW'(in_ready), 0);
        checkOutput("async_ctrl", PW'(out_ctrl), 0);
        checkOutput("async_data", out_data, 0);
        checkOutput("async_occ", PW'(occupancy), 0);
        checkOutput("async_flush_cnt", PW'(flush_cnt), 0);
        doReset();

        // Random traffic with varying downstream pressure and occasional flush.
        for (int i = 0; i < 3000; i++) begin
            logic          iv;
            logic          ordy;
            logic          fl;
            logic [PW-1:0] d;
            iv   = ($urandom % 4) != 0;
            ordy = ((i / 500) % 2 == 0) ? (($urandom % 4) != 0) : (($urandom % 3) == 0);
            fl   = ($urandom % 23) == 0;
            d    = {$urandom, $urandom, $urandom, $urandom};
            applyStimulus(iv, 4'($urandom), d, ordy, fl);
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
